// File: rtl/fetch_stage.sv
// Instruction-fetch stage: request/acknowledge fetch from instruction memory
// into the IF/ID register, with hazard stall, branch flush and memory timeout.
module fetch_stage #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] NOP     = 32'h0000_0000,
  parameter int unsigned      TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             stall,
  input  logic             flush,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             pc_en,
  output logic             if_id_valid,
  output logic [WIDTH-1:0] if_id_instr,
  output logic [WIDTH-1:0] if_id_pc4,
  output logic             fetch_err
);

  // state | meaning
  // IDLE  | latch word-aligned pc_in, request starts next cycle
  // REQ   | imem_req high, waiting for imem_ack
  // HOLD  | fetched word parked in skid buffer until stall drops
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             drop_q, drop_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc4_q, pc4_d;
  logic             commit;
  logic [WIDTH-1:0] commit_instr;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    skid_d       = skid_q;
    drop_d       = drop_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    commit       = 1'b0;
    commit_instr = skid_q;
    case (state_q)
      IDLE: begin
        // flush in IDLE still latches: pc_in already holds the branch target
        addr_d  = {pc_in[WIDTH-1:2], 2'b00};
        cnt_d   = '0;
        state_d = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          cnt_d   = '0;
          drop_d  = 1'b0;
          state_d = IDLE;
          if (!drop_q && !flush) begin
            if (stall) begin
              skid_d  = imem_rdata;
              state_d = HOLD;
            end else begin
              commit       = 1'b1;
              commit_instr = imem_rdata;
            end
          end
        end else begin
          // the request cannot be withdrawn, so a flush only marks it dead
          if (flush) drop_d = 1'b1;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == CNT_MAX - 8'd1) err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          state_d = IDLE;
        end else if (!stall) begin
          commit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (commit) begin
      valid_d = 1'b1;
      instr_d = commit_instr;
      pc4_d   = addr_q + WIDTH'(4);
    end else begin
      valid_d = 1'b0;
      instr_d = NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      skid_q  <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= NOP;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      skid_q  <= skid_d;
      drop_q  <= drop_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  // pc_en is combinational so the PC advances on the same edge IF/ID loads
  assign pc_en       = commit & rst;
  assign imem_req    = (state_q == REQ);
  assign imem_addr   = addr_q;
  assign if_id_valid = valid_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by
// randomized fetch transactions checked against a transaction-level model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_en;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        fetch_err;

  int vectors = 0;
  int miscompares = 0;

  // reference view of IF/ID
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  fetch_stage #(.WIDTH(32), .NOP(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .stall(stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .pc_en(pc_en), .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag);
    chk1({tag, "_valid"}, if_id_valid, m_valid);
    chk32({tag, "_instr"}, if_id_instr, m_instr);
    chk32({tag, "_pc4"}, if_id_pc4, m_pc4);
  endtask

  // One fetch transaction starting from IDLE: ack after wait_n empty REQ
  // cycles, stall held for stall_n HOLD cycles, optional flush while pending.
  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data,
                           input int wait_n, input int stall_n, input bit flush_mid);
    logic [31:0] a;
    a = {pc[31:2], 2'b00};
    pc_in = pc;
    chk1("idle_req", imem_req, 1'b0);
    step();
    m_valid = 1'b0;
    m_instr = NOP;
    chk1("req_high", imem_req, 1'b1);
    chk32("req_addr", imem_addr, a);
    chk_ifid("req_ifid");
    if (stall_n > 0) stall = 1'b1;
    for (int i = 0; i < wait_n; i++) begin
      flush = flush_mid && (i == 0);
      chk1("wait_pcen", pc_en, 1'b0);
      step();
      flush = 1'b0;
      pc_in = $urandom;
      chk1("wait_req", imem_req, 1'b1);
      chk32("wait_addr", imem_addr, a);
    end
    imem_ack = 1'b1;
    imem_rdata = data;
    #1;
    chk1("ack_pcen", pc_en, !flush_mid && stall_n == 0);
    step();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    if (flush_mid) begin
      m_valid = 1'b0;
      m_instr = NOP;
      chk_ifid("discard");
      chk1("discard_req", imem_req, 1'b0);
    end else if (stall_n == 0) begin
      m_valid = 1'b1;
      m_instr = data;
      m_pc4 = a + 32'd4;
      chk_ifid("commit");
    end else begin
      for (int i = 0; i < stall_n; i++) begin
        chk1("hold_req", imem_req, 1'b0);
        chk1("hold_pcen", pc_en, 1'b0);
        chk_ifid("hold_ifid");
        step();
      end
      stall = 1'b0;
      #1;
      chk1("unstall_pcen", pc_en, 1'b1);
      step();
      m_valid = 1'b1;
      m_instr = data;
      m_pc4 = a + 32'd4;
      chk_ifid("unstall_commit");
    end
    stall = 1'b0;
    chk1("post_pcen", pc_en, 1'b0);
  endtask

  initial begin
    int w, s;
    bit f;
    rst = 1'b0;
    pc_in = 32'h0;
    stall = 1'b0;
    flush = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    m_valid = 1'b0;
    m_instr = NOP;
    m_pc4 = 32'h0;
    repeat (3) step();
    chk1("rst_req", imem_req, 1'b0);
    chk32("rst_addr", imem_addr, 32'h0);
    chk1("rst_pcen", pc_en, 1'b0);
    chk_ifid("rst");
    chk1("rst_err", fetch_err, 1'b0);
    rst = 1'b1;

    fetch_one(32'h0040_0000, 32'h2008_0005, 1, 0, 1'b0);
    fetch_one(32'h0040_0004, 32'h1234_5678, 1, 3, 1'b0);
    fetch_one(32'h0040_0008, 32'hDEAD_BEEF, 2, 0, 1'b1);
    fetch_one(32'h0040_0100, 32'h0000_0013, 0, 0, 1'b0);
    fetch_one(32'hFFFF_FFFE, 32'hCAFE_0001, 1, 0, 1'b0);
    chk1("no_err_yet", fetch_err, 1'b0);

    // memory timeout: ack withheld for 20 wait cycles
    pc_in = 32'h0000_1000;
    step();
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) chk1("err_before_timeout", fetch_err, 1'b0);
      if (i == 16) chk1("err_at_timeout", fetch_err, 1'b1);
    end
    chk1("timeout_req", imem_req, 1'b1);
    chk32("timeout_addr", imem_addr, 32'h0000_1000);
    imem_ack = 1'b1;
    imem_rdata = 32'h0BAD_F00D;
    #1;
    chk1("timeout_ack_pcen", pc_en, 1'b1);
    step();
    imem_ack = 1'b0;
    m_valid = 1'b1;
    m_instr = 32'h0BAD_F00D;
    m_pc4 = 32'h0000_1004;
    chk_ifid("timeout_commit");
    chk1("err_sticky", fetch_err, 1'b1);

    for (int n = 0; n < 40; n++) begin
      w = $urandom_range(0, 4);
      f = (w > 0) && ($urandom_range(0, 3) == 0);
      s = (!f && $urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      fetch_one($urandom, $urandom, w, s, f);
    end
    chk1("err_still_sticky", fetch_err, 1'b1);

    // reset in the middle of a pending request, ack arriving afterwards
    pc_in = 32'h0000_2000;
    step();
    chk1("mid_req", imem_req, 1'b1);
    rst = 1'b0;
    step();
    m_valid = 1'b0;
    m_instr = NOP;
    m_pc4 = 32'h0;
    chk1("mrst_req", imem_req, 1'b0);
    chk32("mrst_addr", imem_addr, 32'h0);
    chk_ifid("mrst");
    chk1("mrst_err", fetch_err, 1'b0);
    imem_ack = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    #1;
    chk1("mrst_ack_pcen", pc_en, 1'b0);
    step();
    rst = 1'b1;
    pc_in = 32'h0000_3000;
    #1;
    chk1("idle_ack_pcen", pc_en, 1'b0);
    step();
    imem_ack = 1'b0;
    chk_ifid("restart_ifid");
    chk1("restart_req", imem_req, 1'b1);
    chk32("restart_addr", imem_addr, 32'h0000_3000);
    imem_ack = 1'b1;
    imem_rdata = 32'h0000_0033;
    #1;
    chk1("restart_pcen", pc_en, 1'b1);
    step();
    imem_ack = 1'b0;
    m_valid = 1'b1;
    m_instr = 32'h0000_0033;
    m_pc4 = 32'h0000_3004;
    chk_ifid("restart_commit");
    chk1("restart_err", fetch_err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

endmodule
